// File: rtl/clint_smp_if.sv
// MMIO bus between the system memory controller (master) and the CLINT (slave).
// Carries one access per cycle in each direction; only a read produces a response.
interface clint_smp_if;
    // The master pulses w_req for a single cycle and qualifies it with w_we.
    // There is no ready signal because the slave accepts every request.
    // A read answers with r_rvalid high for exactly one cycle, one cycle after w_req,
    // and r_rdata keeps that value until the next read response.
    logic        w_req;
    logic        w_we;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    modport master (
        output w_req, w_we, w_addr, w_wdata, w_be,
        input  r_rdata, r_rvalid
    );

    modport slave (
        input  w_req, w_we, w_addr, w_wdata, w_be,
        output r_rdata, r_rvalid
    );
endinterface

// File: rtl/clint_smp.sv
// Core-local interruptor: shared prescaled 64-bit mtime plus per-hart mtimecmp and msip,
// driving timer and software interrupt levels into the SMP cluster.
module clint_smp #(
    parameter int N_HARTS  = 1,
    parameter int TICK_DIV = 1
) (
    input  logic               CLK,
    input  logic               RST_X,
    clint_smp_if.slave         bus,
    output logic [63:0]        w_mtime,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip
);
    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q [N_HARTS];
    logic [63:0]        mtimecmp_d [N_HARTS];
    logic [N_HARTS-1:0] msip_q, msip_d;
    logic [N_HARTS-1:0] mtip_q, mtip_d;
    logic [31:0]        shadow_hi_q, shadow_hi_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [13:0] word;
    logic        wr, rd, tick;
    logic        msip_hit, cmp_hit, mtime_lo_hit, mtime_hi_hit;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign word         = bus.w_addr[15:2];
    assign wr           = bus.w_req & bus.w_we;
    assign rd           = bus.w_req & ~bus.w_we;
    assign tick         = (presc_q == PRESC_MAX);
    // Out-of-range hart indices never hit, so they fall through to read-0 / write-drop.
    assign msip_hit     = (word[13:3] == 11'h000) && (int'(word[2:0]) < N_HARTS);
    assign cmp_hit      = (word[13:4] == 10'h100) && (int'(word[3:1]) < N_HARTS);
    assign mtime_lo_hit = (word == 14'h2FFE);
    assign mtime_hi_hit = (word == 14'h2FFF);

    always_comb begin
        presc_d     = tick ? '0 : presc_q + PW'(1);
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        msip_d      = msip_q;
        shadow_hi_d = shadow_hi_q;
        rdata_d     = rdata_q;
        rvalid_d    = rd;
        for (int h = 0; h < N_HARTS; h++) begin
            mtimecmp_d[h] = mtimecmp_q[h];
        end

        if (wr) begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (msip_hit && word[2:0] == 3'(h) && bus.w_be[0]) begin
                    msip_d[h] = bus.w_wdata[0];
                end
                if (cmp_hit && word[3:1] == 3'(h)) begin
                    if (word[0]) begin
                        mtimecmp_d[h][63:32] = merge_be(mtimecmp_q[h][63:32], bus.w_wdata, bus.w_be);
                    end else begin
                        mtimecmp_d[h][31:0] = merge_be(mtimecmp_q[h][31:0], bus.w_wdata, bus.w_be);
                    end
                end
            end
            // A software write to mtime overrides this cycle's tick and restarts the prescaler.
            if (mtime_lo_hit) begin
                mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], bus.w_wdata, bus.w_be)};
                presc_d = '0;
            end
            if (mtime_hi_hit) begin
                mtime_d = {merge_be(mtime_q[63:32], bus.w_wdata, bus.w_be), mtime_q[31:0]};
                presc_d = '0;
            end
        end

        if (rd) begin
            rdata_d = '0;
            for (int h = 0; h < N_HARTS; h++) begin
                if (msip_hit && word[2:0] == 3'(h)) rdata_d = {31'b0, msip_q[h]};
                if (cmp_hit && word[3:1] == 3'(h)) begin
                    rdata_d = word[0] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
                end
            end
            // The low-half read snapshots the high half so a lo-then-hi pair never tears.
            if (mtime_lo_hit) begin
                rdata_d     = mtime_q[31:0];
                shadow_hi_d = mtime_q[63:32];
            end
            if (mtime_hi_hit) rdata_d = shadow_hi_q;
        end

        for (int h = 0; h < N_HARTS; h++) begin
            mtip_d[h] = (mtime_d >= mtimecmp_d[h]);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            presc_q     <= '0;
            mtime_q     <= '0;
            msip_q      <= '0;
            mtip_q      <= '0;
            shadow_hi_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            for (int h = 0; h < N_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            shadow_hi_q <= shadow_hi_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            for (int h = 0; h < N_HARTS; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign bus.r_rdata  = rdata_q;
    assign bus.r_rvalid = rvalid_q;
    assign w_mtime      = mtime_q;
    assign w_mtip       = mtip_q;
    assign w_msip       = msip_q;
endmodule

// File: tb/tb_clint_smp.sv
// Bench for clint_smp: one instance per prescaler setting, directed MMIO traffic,
// read responses checked against an expected queue by an independent monitor.
module tb_clint_smp;
    logic CLK;
    logic RST_X;

    clint_smp_if bus1 ();
    clint_smp_if bus4 ();

    logic [63:0] mtime1, mtime4;
    logic [1:0]  mtip1, msip1, mtip4, msip4;

    clint_smp #(.N_HARTS(2), .TICK_DIV(1)) dut1 (
        .CLK(CLK), .RST_X(RST_X), .bus(bus1.slave),
        .w_mtime(mtime1), .w_mtip(mtip1), .w_msip(msip1)
    );

    clint_smp #(.N_HARTS(2), .TICK_DIV(4)) dut4 (
        .CLK(CLK), .RST_X(RST_X), .bus(bus4.slave),
        .w_mtime(mtime4), .w_mtip(mtip4), .w_msip(msip4)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge CLK);
        bus1.w_req   = 1'b1;
        bus1.w_we    = 1'b1;
        bus1.w_addr  = addr;
        bus1.w_wdata = data;
        bus1.w_be    = be;
        @(posedge CLK);
        #1;
        bus1.w_req   = 1'b0;
        bus1.w_we    = 1'b0;
    endtask

    task automatic bus_issue_read(input logic [15:0] addr);
        @(negedge CLK);
        bus1.w_req  = 1'b1;
        bus1.w_we   = 1'b0;
        bus1.w_addr = addr;
        bus1.w_be   = 4'h0;
        @(posedge CLK);
        #1;
        bus1.w_req  = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [15:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        bus_issue_read(addr);
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (RST_X && bus1.r_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_rvalid: got rdata %h with no read outstanding", bus1.r_rdata);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus1.r_rdata !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", nm, bus1.r_rdata, e);
                end
            end
        end
    end

    initial begin
        logic found;
        bus1.w_req = 1'b0; bus1.w_we = 1'b0; bus1.w_addr = '0; bus1.w_wdata = '0; bus1.w_be = '0;
        bus4.w_req = 1'b0; bus4.w_we = 1'b0; bus4.w_addr = '0; bus4.w_wdata = '0; bus4.w_be = '0;

        RST_X = 1'b1;
        #2 RST_X = 1'b0;
        #1;
        check("rst_mtime1", mtime1, 64'd0);
        check("rst_mtime4", mtime4, 64'd0);
        check("rst_mtip", {mtip1, mtip4}, 4'b0);
        check("rst_rvalid", bus1.r_rvalid, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;

        // T2: prescaled and undivided tick rates
        repeat (40) @(posedge CLK);
        #1;
        check("tick_div4", mtime4, 64'd10);
        check("tick_div1", mtime1, 64'd40);

        // T4: software interrupt bit and byte-lane gating
        bus_write(16'h0004, 32'hFFFF_FFFF, 4'b0001);
        check("msip_set", msip1, 2'b10);
        bus_read("msip_read1", 16'h0004, 32'h0000_0001);
        bus_write(16'h0004, 32'h0000_0000, 4'b1111);
        check("msip_clr", msip1, 2'b00);
        bus_write(16'h0000, 32'h0000_0001, 4'b0010);
        check("msip_be_gate", msip1, 2'b00);

        // T1: asynchronous reset mid-run drops a pending read response
        bus_write(16'h0000, 32'h0000_0001, 4'b0001);
        check("msip0_set", msip1, 2'b01);
        bus_issue_read(16'hBFF8);
        #1 RST_X = 1'b0;
        #1;
        check("arst_mtime1", mtime1, 64'd0);
        check("arst_mtime4", mtime4, 64'd0);
        check("arst_msip", msip1, 2'b00);
        check("arst_rvalid", bus1.r_rvalid, 1'b0);
        @(negedge CLK);
        RST_X = 1'b1;
        bus_read("rst_cmp0_lo", 16'h4000, 32'hFFFF_FFFF);
        bus_read("rst_cmp1_hi", 16'h400C, 32'hFFFF_FFFF);
        bus_read("rst_shadow", 16'hBFFC, 32'h0000_0000);
        bus_write(16'h4000, 32'h0000_AB00, 4'b0010);
        bus_read("cmp_be_lane1", 16'h4000, 32'hFFFF_ABFF);

        // T3: hart1 timer interrupt rises with mtime==100 and falls when mtimecmp is raised
        bus_write(16'hBFFC, 32'h0, 4'hF);
        bus_write(16'hBFF8, 32'h0, 4'hF);
        check("mtime_zeroed", mtime1, 64'd0);
        bus_write(16'h400C, 32'h0, 4'hF);
        bus_write(16'h4008, 32'd100, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge CLK);
            if (mtime1 == 64'd99) found = 1'b1;
        end
        check("t3_reach99", found, 1'b1);
        check("mtip_at99", mtip1, 2'b00);
        @(negedge CLK);
        check("mtime_100", mtime1, 64'd100);
        check("mtip_at100", mtip1, 2'b10);
        bus_write(16'h4008, 32'hFFFF_FFFF, 4'hF);
        bus_write(16'h400C, 32'hFFFF_FFFF, 4'hF);
        check("mtip_fall", mtip1, 2'b00);

        // T5: lo read snapshots hi across a carry
        bus_write(16'hBFFC, 32'h0, 4'hF);
        bus_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        check("t5_mtime_set", mtime1, 64'h0000_0000_FFFF_FFFF);
        bus_read("atomic_lo", 16'hBFF8, 32'hFFFF_FFFF);
        repeat (3) @(posedge CLK);
        #1;
        check("live_hi", mtime1[63:32], 32'h1);
        bus_read("atomic_hi", 16'hBFFC, 32'h0000_0000);

        // T6: mtime write beats the tick; unmapped harts are inert
        bus_write(16'hBFF8, 32'd5, 4'hF);
        check("collision", mtime1, 64'h0000_0001_0000_0005);
        @(posedge CLK);
        #1;
        check("tick_resumes", mtime1, 64'h0000_0001_0000_0006);
        bus_write(16'h0010, 32'hFFFF_FFFF, 4'hF);
        bus_write(16'h0008, 32'hFFFF_FFFF, 4'hF);
        check("oob_msip", msip1, 2'b00);
        bus_read("oob_read_0010", 16'h0010, 32'h0);
        bus_read("oob_read_0008", 16'h0008, 32'h0);
        bus_read("oob_cmp2", 16'h4010, 32'h0);
        bus_read("unmapped", 16'h1234, 32'h0);

        repeat (4) @(negedge CLK);
        while (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_rvalid: got no response expected %h", exp_q.pop_front());
            void'(name_q.pop_front());
        end

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
